pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Decode-stage hazard controller that drives the ID/EXE pipeline register from the upstream side. It compares the source registers of the instruction in ID against the destination fields already latched in ID/EXE and EXE/MEM. From that comparison it produces operand-forwarding selects, a load-use stall, and a bubble that zeroes the control bits written into ID/EXE. It also keeps a stall-sequence checker and optional performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock; all flops update on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- rs  in  5  source register A of the instruction in ID.
- rt  in  5  source register B of the instruction in ID.
- use_rs  in  1  1 when the ID instruction reads rs.
- use_rt  in  1  1 when the ID instruction reads rt.
- ewreg, em2reg  in  1 each  write-enable and load flag currently held in ID/EXE.
- ern  in  5  destination register currently held in ID/EXE.
- mwreg, mm2reg  in  1 each  write-enable and load flag held in EXE/MEM.
- mrn  in  5  destination register held in EXE/MEM.
- perf_clr  in  1  synchronous clear of the performance counters.
- fwda, fwdb  out  2  operand select: 00 register file, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
- wpcir  out  1  0 = hold PC and IF/ID this cycle.
- bubble  out  1  1 = force dwreg, dm2reg, dwmem and djal to 0 at the ID/EXE input.
- hz_err  out  1  sticky protocol error flag.
- perf_stall, perf_fwd, perf_cyc  out  CNT_W each  performance counters.

## Operation
- Match conditions:
  - exe_hit(r) = ewreg & (ern != 0) & (ern == r).
  - mem_hit(r) = mwreg & (mrn != 0) & (mrn == r).
  - Register 0 is never forwarded and never causes a stall.
- Forward select for each operand (rs drives fwda, rt drives fwdb), in priority order:
  - exe_hit & !em2reg -> 01.
  - else mem_hit & mm2reg -> 11.
  - else mem_hit -> 10.
  - else 00.
  - The use_* flag does not gate the select, but an unused operand can never cause a stall.
- Load-use stall: stall = ewreg & em2reg & (ern != 0) & ((use_rs & ern == rs) | (use_rt & ern == rt)).
  - wpcir = !stall.
  - bubble = stall.
  - fwda and fwdb are still driven during a stall; the downstream register discards them.
- Stall checker:
  - Flop stalled_q <= stall.
  - If stall & stalled_q, set hz_err. This condition means the bubble was not honoured for two consecutive cycles.
  - hz_err clears only on reset.
- Outputs while clrn = 0:
  - Forced to fwda = fwdb = 00, wpcir = 1, bubble = 0, regardless of inputs.
  - stalled_q, hz_err and all counters reset to 0.
- Counters (when compiled in):
  - perf_cyc increments every cycle.
  - perf_stall increments in every cycle with stall = 1.
  - perf_fwd increments in every cycle with stall = 0 and (fwda != 00 | fwdb != 00).
  - All three saturate at all-ones; they do not wrap.
  - perf_clr = 1 zeroes all three on the next edge. Clear has priority over increment in the same cycle.

## Timing
- fwda, fwdb, wpcir and bubble are combinational from their inputs, with zero latency. They must settle within the same cycle so that the PC, IF/ID and ID/EXE registers capture them on the next edge.
- Load followed by a dependent instruction:
  - Cycle N: stall = 1.
  - Edge N+1: the load moves to EXE/MEM, and ID/EXE captures a bubble (ewreg = 0).
  - Cycle N+1: stall = 0 and the select is 11.
- Exactly one stall cycle per load-use pair.
- hz_err and the counters are registered: they change 1 cycle after the triggering condition.
- Asynchronous reset asserted mid-stall: wpcir goes to 1 immediately. After reset deasserts, the first cycle is evaluated fresh, with stalled_q = 0.

## Configuration
- HAZARD_PERF_EN defined: the three CNT_W-bit counters and the perf_clr logic are built.
- HAZARD_PERF_EN undefined:
  - perf_stall, perf_fwd and perf_cyc are tied to 0.
  - perf_clr is ignored.
  - No counter flops exist.
  - Forwarding, stall and hz_err behaviour is identical in both builds.

## Test plan
- Forwarding from EXE: ewreg=1, em2reg=0, ern=5, rs=5, use_rs=1 -> fwda=01, wpcir=1, bubble=0.
- Load-use stall: ewreg=1, em2reg=1, ern=7, rt=7, use_rt=1 for one cycle, then the load is shifted into MEM (mwreg=1, mm2reg=1, mrn=7) with ewreg=0 -> cycle 1: wpcir=0, bubble=1; cycle 2: fwdb=11, wpcir=1; perf_stall=1.
- Priority and register 0:
  - ern=mrn=3, ewreg=mwreg=1, em2reg=0, rs=3 -> fwda=01.
  - ern=mrn=0 with rs=0 -> fwda=00, no stall.
- Checker: hold the load-use condition for 2 consecutive cycles -> hz_err=1 after the 2nd edge; it stays 1 until clrn=0.
- Counters (HAZARD_PERF_EN):
  - Run 10 cycles with 3 stalls and 4 forwards -> perf_cyc=10, perf_stall=3, perf_fwd=4.
  - Assert perf_clr -> all 0 next cycle.
  - Preload near all-ones -> counters saturate and do not wrap.
- Reset: assert clrn=0 asynchronously during a stall -> wpcir=1 and bubble=0 immediately; hz_err=0 and all counters=0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard controller: forwarding selects, load-use stall/bubble,
// stall-sequence checker and optional counters (built when HAZARD_PERF_EN is defined).
module pipe_hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic             perf_clr,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             hz_err,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_fwd,
  output logic [CNT_W-1:0] perf_cyc
);

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXE  = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  logic       exe_valid;
  logic       mem_valid;
  logic       exe_hit_a;
  logic       exe_hit_b;
  logic       mem_hit_a;
  logic       mem_hit_b;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;
  logic       stalled_q;
  logic       err_q;

  // Register 0 is hardwired, so a zero destination never matches anything.
  assign exe_valid = ewreg & (ern != 5'd0);
  assign mem_valid = mwreg & (mrn != 5'd0);

  assign exe_hit_a = exe_valid & (ern == rs);
  assign exe_hit_b = exe_valid & (ern == rt);
  assign mem_hit_a = mem_valid & (mrn == rs);
  assign mem_hit_b = mem_valid & (mrn == rt);

  // A load in EXE has no data yet; fall through to MEM (the stall covers it).
  always_comb begin
    sel_a = SEL_RF;
    if (exe_hit_a && !em2reg) begin
      sel_a = SEL_EXE;
    end else if (mem_hit_a && mm2reg) begin
      sel_a = SEL_LOAD;
    end else if (mem_hit_a) begin
      sel_a = SEL_MEM;
    end
  end

  always_comb begin
    sel_b = SEL_RF;
    if (exe_hit_b && !em2reg) begin
      sel_b = SEL_EXE;
    end else if (mem_hit_b && mm2reg) begin
      sel_b = SEL_LOAD;
    end else if (mem_hit_b) begin
      sel_b = SEL_MEM;
    end
  end

  assign stall = exe_valid & em2reg &
                 ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

  // Outputs are forced to their idle values while reset is held.
  assign fwda   = clrn ? sel_a : SEL_RF;
  assign fwdb   = clrn ? sel_b : SEL_RF;
  assign wpcir  = ~(clrn & stall);
  assign bubble = clrn & stall;
  assign hz_err = err_q;

  // A stall seen twice in a row means the bubble was not written into ID/EXE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stalled_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stalled_q <= stall;
      if (stall && stalled_q) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             fwd_active;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] fwd_q;
  logic [CNT_W-1:0] cyc_q;

  assign fwd_active = ~stall & ((sel_a != SEL_RF) | (sel_b != SEL_RF));

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_q <= '0;
      fwd_q   <= '0;
      cyc_q   <= '0;
    end else if (perf_clr) begin
      stall_q <= '0;
      fwd_q   <= '0;
      cyc_q   <= '0;
    end else begin
      if (cyc_q != CNT_MAX) begin
        cyc_q <= cyc_q + 1'b1;
      end
      if (stall && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (fwd_active && (fwd_q != CNT_MAX)) begin
        fwd_q <= fwd_q + 1'b1;
      end
    end
  end

  assign perf_stall = stall_q;
  assign perf_fwd   = fwd_q;
  assign perf_cyc   = cyc_q;
`else
  logic perf_clr_unused;

  assign perf_clr_unused = perf_clr;
  assign perf_stall      = '0;
  assign perf_fwd        = '0;
  assign perf_cyc        = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed steps plus random traffic against a rule-level model.
module tb_pipe_hazard_unit;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [4:0]       rs, rt, ern, mrn;
  logic             use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, perf_clr;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, bubble, hz_err;
  logic [CNT_W-1:0] perf_stall, perf_fwd, perf_cyc;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  bit m_stalled, m_err;
  int m_stall_c, m_fwd_c, m_cyc_c;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg),
    .mrn(mrn), .perf_clr(perf_clr), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
    .bubble(bubble), .hz_err(hz_err), .perf_stall(perf_stall), .perf_fwd(perf_fwd),
    .perf_cyc(perf_cyc)
  );

  function automatic logic [1:0] ref_sel(input logic [4:0] r);
    bit e, m;
    e = ewreg && (ern != 0) && (ern == r);
    m = mwreg && (mrn != 0) && (mrn == r);
    if (e && !em2reg) return 2'd1;
    if (m) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic bit ref_stall();
    if (!ewreg || !em2reg || ern == 0) return 1'b0;
    return (use_rs && rs == ern) || (use_rt && rt == ern);
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rs = 0; rt = 0; use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0; ern = 0;
    mwreg = 0; mm2reg = 0; mrn = 0; perf_clr = 0;
  endtask

  task automatic model_reset();
    m_stalled = 0; m_err = 0; m_stall_c = 0; m_fwd_c = 0; m_cyc_c = 0;
  endtask

  task automatic chk_regs();
    chk("hz_err", {31'd0, hz_err}, {31'd0, m_err});
    chk("perf_stall", {24'd0, perf_stall}, exp_cnt(m_stall_c));
    chk("perf_fwd", {24'd0, perf_fwd}, exp_cnt(m_fwd_c));
    chk("perf_cyc", {24'd0, perf_cyc}, exp_cnt(m_cyc_c));
  endtask

  // Inputs are driven just after a rising edge; checks combinational outputs,
  // advances one edge and checks the registered state.
  task automatic cyc();
    bit s, f;
    logic [1:0] ea, eb;
    #2;
    ea = ref_sel(rs); eb = ref_sel(rt); s = ref_stall();
    f = !s && (ea != 0 || eb != 0);
    chk("fwda", {30'd0, fwda}, {30'd0, ea});
    chk("fwdb", {30'd0, fwdb}, {30'd0, eb});
    chk("wpcir", {31'd0, wpcir}, {31'd0, !s});
    chk("bubble", {31'd0, bubble}, {31'd0, s});
    @(posedge clk);
    if (s && m_stalled) m_err = 1;
    m_stalled = s;
    if (perf_clr) begin
      m_stall_c = 0; m_fwd_c = 0; m_cyc_c = 0;
    end else begin
      m_cyc_c = (m_cyc_c < CMAX) ? m_cyc_c + 1 : CMAX;
      if (s) m_stall_c = (m_stall_c < CMAX) ? m_stall_c + 1 : CMAX;
      if (f) m_fwd_c = (m_fwd_c < CMAX) ? m_fwd_c + 1 : CMAX;
    end
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    clrn = 0;
    model_reset();
    #1;
    chk("rst_fwda", {30'd0, fwda}, 32'd0);
    chk("rst_fwdb", {30'd0, fwdb}, 32'd0);
    chk("rst_wpcir", {31'd0, wpcir}, 32'd1);
    chk("rst_bubble", {31'd0, bubble}, 32'd0);
    chk_regs();
    @(posedge clk);
    #1;
    clrn = 1;
  endtask

  task automatic set_load_use();
    clear_in();
    ewreg = 1; em2reg = 1; ern = 7; rt = 7; use_rt = 1;
  endtask

  task automatic set_fwd();
    clear_in();
    ewreg = 1; em2reg = 0; ern = 5; rs = 5; use_rs = 1;
  endtask

  initial begin
    clear_in();
    model_reset();
    do_reset();

    // forwarding from EXE
    set_fwd();
    #2;
    chk("exe_fwda", {30'd0, fwda}, 32'd1);
    chk("exe_wpcir", {31'd0, wpcir}, 32'd1);
    cyc();

    // load-use: one stall, then the load sits in MEM
    set_load_use();
    #2;
    chk("lu_wpcir", {31'd0, wpcir}, 32'd0);
    chk("lu_bubble", {31'd0, bubble}, 32'd1);
    cyc();
    clear_in();
    mwreg = 1; mm2reg = 1; mrn = 7; rt = 7; use_rt = 1;
    #2;
    chk("lu_fwdb", {30'd0, fwdb}, 32'd3);
    chk("lu_wpcir2", {31'd0, wpcir}, 32'd1);
    cyc();
    chk("lu_no_err", {31'd0, hz_err}, 32'd0);

    // EXE wins over MEM; register 0 is never matched
    clear_in();
    ewreg = 1; mwreg = 1; ern = 3; mrn = 3; rs = 3; use_rs = 1;
    #2;
    chk("prio_fwda", {30'd0, fwda}, 32'd1);
    cyc();
    clear_in();
    ewreg = 1; em2reg = 1; mwreg = 1; use_rs = 1; use_rt = 1;
    #2;
    chk("r0_fwda", {30'd0, fwda}, 32'd0);
    chk("r0_wpcir", {31'd0, wpcir}, 32'd1);
    cyc();

    // unused operand cannot stall
    set_load_use();
    use_rt = 0;
    cyc();

    // checker: two consecutive stalls latch hz_err until reset
    set_load_use();
    cyc();
    cyc();
    chk("err_set", {31'd0, hz_err}, 32'd1);
    clear_in();
    cyc();
    cyc();
    chk("err_sticky", {31'd0, hz_err}, 32'd1);

    // async reset in the middle of a stall
    set_load_use();
    mwreg = 1; mrn = 7;
    #2;
    chk("pre_rst_bubble", {31'd0, bubble}, 32'd1);
    clrn = 0;
    model_reset();
    #1;
    chk("mid_rst_wpcir", {31'd0, wpcir}, 32'd1);
    chk("mid_rst_bubble", {31'd0, bubble}, 32'd0);
    chk("mid_rst_fwda", {30'd0, fwda}, 32'd0);
    chk("mid_rst_err", {31'd0, hz_err}, 32'd0);
    chk_regs();
    @(posedge clk);
    #1;
    clrn = 1;
    cyc();

    // counters: clear, then 3 stalls / 4 forwards / 3 idle
    clear_in();
    perf_clr = 1;
    cyc();
    set_load_use(); cyc();
    clear_in();     cyc();
    set_load_use(); cyc();
    set_fwd();      cyc();
    set_load_use(); cyc();
    set_fwd();      cyc();
    set_fwd();      cyc();
    set_fwd();      cyc();
    clear_in();     cyc();
    clear_in();     cyc();
`ifdef HAZARD_PERF_EN
    chk("cnt_cyc10", {24'd0, perf_cyc}, 32'd10);
    chk("cnt_stall3", {24'd0, perf_stall}, 32'd3);
    chk("cnt_fwd4", {24'd0, perf_fwd}, 32'd4);
`endif
    perf_clr = 1;
    set_fwd();
    perf_clr = 1;
    cyc();
`ifdef HAZARD_PERF_EN
    chk("clr_cyc", {24'd0, perf_cyc}, 32'd0);
    chk("clr_fwd", {24'd0, perf_fwd}, 32'd0);
`endif

    // saturation
    perf_clr = 0;
    for (int i = 0; i < CMAX + 5; i++) cyc();
`ifdef HAZARD_PERF_EN
    chk("sat_cyc", {24'd0, perf_cyc}, CMAX);
    chk("sat_fwd", {24'd0, perf_fwd}, CMAX);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom_range(0, 1)); use_rt = 1'($urandom_range(0, 1));
      ewreg = 1'($urandom_range(0, 1)); em2reg = 1'($urandom_range(0, 1));
      mwreg = 1'($urandom_range(0, 1)); mm2reg = 1'($urandom_range(0, 1));
      perf_clr = ($urandom_range(0, 15) == 0);
      cyc();
      if (i % 75 == 74) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
